// File: rtl/vga_text_arbiter.sv
// 70x30 text buffer: 1-cycle display read port, round-robin write arbitration, clear engine.
// Optional VGA_TEXT_BLANK_WR_EN: buffer writes only in cycles with valid=0 (blanking).
module vga_text_arbiter #(
  parameter int unsigned COLS       = 70,
  parameter int unsigned ROWS       = 30,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       valid,
  input  logic [6:0] rd_x,
  input  logic [4:0] rd_y,
  output logic [7:0] rd_char,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] x0,
  input  logic [6:0] x1,
  input  logic [4:0] y0,
  input  logic [4:0] y1,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  output logic       ack0,
  output logic       ack1,
  input  logic       clr_start,
  output logic       busy,
  output logic       err
);

  localparam int unsigned AW        = 12;
  localparam int unsigned DEPTH     = COLS * ROWS;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [6:0]  COLS_L    = 7'(COLS);
  localparam logic [4:0]  ROWS_L    = 5'(ROWS);

  typedef enum logic [0:0] {ST_CLEAR, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            last_q, last_d;
  logic            err_d;

  logic [7:0]      mem_q [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [7:0]      mem_wdata;

  // y*70 as (y<<6) + (y<<2) + (y<<1), plus x
  function automatic logic [AW-1:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
    return AW'({y, 6'b0}) + AW'({y, 2'b0}) + AW'({y, 1'b0}) + AW'(x);
  endfunction

  logic wr_slot;
`ifdef VGA_TEXT_BLANK_WR_EN
  assign wr_slot = ~valid;
`else
  logic unused_valid;
  assign unused_valid = valid;
  assign wr_slot      = 1'b1;
`endif

  logic          gnt_idx;
  logic [6:0]    wr_x;
  logic [4:0]    wr_y;
  logic [7:0]    wr_data;
  logic          wr_in_range;
  logic [AW-1:0] wr_addr;

  // On a tie the requester that did not win last time is served
  assign gnt_idx     = (req0 & req1) ? ~last_q : req1;
  assign wr_x        = gnt_idx ? x1 : x0;
  assign wr_y        = gnt_idx ? y1 : y0;
  assign wr_data     = gnt_idx ? d1 : d0;
  assign wr_in_range = (wr_x < COLS_L) && (wr_y < ROWS_L);
  assign wr_addr     = cell_addr(wr_x, wr_y);

  logic          rd_in_range;
  logic [AW-1:0] rd_addr;
  assign rd_in_range = (rd_x < COLS_L) && (rd_y < ROWS_L);
  assign rd_addr     = cell_addr(rd_x, rd_y);

  assign busy = (state_q == ST_CLEAR);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    last_d     = last_q;
    err_d      = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    case (state_q)
      ST_CLEAR: begin
        if (wr_slot) begin
          mem_we    = 1'b1;
          mem_waddr = clr_addr_q;
          mem_wdata = BLANK_CHAR;
          if (clr_addr_q == LAST_ADDR) begin
            clr_addr_d = '0;
            state_d    = ST_RUN;
          end else begin
            clr_addr_d = clr_addr_q + AW'(1);
          end
        end
      end
      ST_RUN: begin
        // A clear command pre-empts any pending request
        if (clr_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else if (wr_slot && (req0 || req1)) begin
          ack0   = ~gnt_idx;
          ack1   = gnt_idx;
          last_d = gnt_idx;
          if (wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      last_q     <= 1'b1;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      last_q     <= last_d;
      err        <= err_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held
  always_ff @(posedge pclk) begin
    if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
  end

  // Read-before-write: a same-cycle write is seen one cycle later
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) rd_char <= 8'h00;
    else       rd_char <= rd_in_range ? mem_q[rd_addr] : BLANK_CHAR;
  end

endmodule

// File: tb/tb_vga_text_arbiter.sv
// Bench for vga_text_arbiter: directed steps plus random traffic against a cycle-level buffer model.
module tb_vga_text_arbiter;

  logic       pclk = 1'b0;
  logic       reset;
  logic       valid;
  logic [6:0] rd_x;
  logic [4:0] rd_y;
  logic [7:0] rd_char;
  logic       req0, req1;
  logic [6:0] x0, x1;
  logic [4:0] y0, y1;
  logic [7:0] d0, d1;
  logic       ack0, ack1;
  logic       clr_start;
  logic       busy;
  logic       err;

  always #20 pclk = ~pclk;

  vga_text_arbiter dut (
    .pclk(pclk), .reset(reset), .valid(valid), .rd_x(rd_x), .rd_y(rd_y), .rd_char(rd_char),
    .req0(req0), .req1(req1), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .d0(d0), .d1(d1),
    .ack0(ack0), .ack1(ack1), .clr_start(clr_start), .busy(busy), .err(err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: plain array of cells plus clear progress and tie-break history
  byte unsigned ref_mem [2100];
  bit           ref_known [2100];
  bit           m_clearing;
  int           m_clr_idx;
  int           m_last;
  logic [7:0]   m_rd;
  bit           m_rd_known;
  bit           m_err;
  bit           m_g0, m_g1;

  int dut_busy_cnt;
  int ack0_cnt, ack1_cnt;
  int ack_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit on_screen(input int x, input int y);
    return (x < 70) && (y < 30);
  endfunction

  task automatic model_reset();
    m_clearing = 1'b1;
    m_clr_idx  = 0;
    m_last     = 1;
    m_rd       = 8'h00;
    m_rd_known = 1'b1;
    m_err      = 1'b0;
  endtask

  // One clock: check outputs at negedge, advance model, return at posedge+1
  task automatic cycle();
    bit slot, grant;
    int g, wx, wy, ra;
    logic [7:0] wd;
    @(negedge pclk);
    slot = 1'b1;
`ifdef VGA_TEXT_BLANK_WR_EN
    slot = !valid;
`endif
    grant = !m_clearing && !clr_start && slot && (req0 || req1);
    g     = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
    m_g0  = grant && (g == 0);
    m_g1  = grant && (g == 1);
    chk("ack0", 32'(ack0), 32'(m_g0));
    chk("ack1", 32'(ack1), 32'(m_g1));
    chk("busy", 32'(busy), 32'(m_clearing));
    chk("err",  32'(err),  32'(m_err));
    if (m_rd_known) chk("rd_char", 32'(rd_char), 32'(m_rd));
    if (busy === 1'b1) dut_busy_cnt++;
    if (ack0 === 1'b1) begin ack0_cnt++; ack_log.push_back(0); end
    if (ack1 === 1'b1) begin ack1_cnt++; ack_log.push_back(1); end

    if (on_screen(int'(rd_x), int'(rd_y))) begin
      ra         = int'(rd_y) * 70 + int'(rd_x);
      m_rd       = ref_mem[ra];
      m_rd_known = ref_known[ra];
    end else begin
      m_rd       = 8'h20;
      m_rd_known = 1'b1;
    end

    m_err = 1'b0;
    if (grant) begin
      wx = (g == 1) ? int'(x1) : int'(x0);
      wy = (g == 1) ? int'(y1) : int'(y0);
      wd = (g == 1) ? d1 : d0;
      m_last = g;
      if (on_screen(wx, wy)) begin
        ref_mem[wy * 70 + wx]   = wd;
        ref_known[wy * 70 + wx] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end

    if (m_clearing) begin
      if (slot) begin
        ref_mem[m_clr_idx]   = 8'h20;
        ref_known[m_clr_idx] = 1'b1;
        m_clr_idx++;
        if (m_clr_idx == 2100) m_clearing = 1'b0;
      end
    end else if (clr_start) begin
      m_clearing = 1'b1;
      m_clr_idx  = 0;
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic read_expect(input string tag, input int x, input int y, input logic [7:0] exp);
    rd_x = 7'(x);
    rd_y = 5'(y);
    cycle();
    chk(tag, 32'(rd_char), 32'(exp));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend0, pend1;
    int exp_log[4];

    reset = 1'b1; valid = 1'b0; rd_x = '0; rd_y = '0; clr_start = 1'b0;
    req0 = 1'b0; req1 = 1'b0; x0 = '0; x1 = '0; y0 = '0; y1 = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < 2100; i++) ref_known[i] = 1'b0;

    // Reset values
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_rd_char", 32'(rd_char), 32'h00);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge pclk); #1;
    reset = 1'b0;
    model_reset();

    // Power-up clear lasts exactly 2100 cycles
    dut_busy_cnt = 0;
    run(2110);
    chk("busy_len_boot", 32'(dut_busy_cnt), 32'd2100);
    read_expect("rd_0_0", 0, 0, 8'h20);
    read_expect("rd_69_29", 69, 29, 8'h20);
    read_expect("rd_35_12", 35, 12, 8'h20);

    // Single write by requester 0
    ack0_cnt = 0;
    req0 = 1'b1; x0 = 7'd5; y0 = 5'd3; d0 = 8'h31;
    cycle();
    req0 = 1'b0;
    run(3);
    chk("ack0_once", 32'(ack0_cnt), 32'd1);
    chk("mem215", 32'(dut.mem_q[215]), 32'h31);
    read_expect("rd_5_3", 5, 3, 8'h31);
    read_expect("rd_4_3", 4, 3, 8'h20);
    read_expect("rd_6_3", 6, 3, 8'h20);

    // Out-of-range write by requester 1 is acked, dropped, flagged
    req1 = 1'b1; x1 = 7'd70; y1 = 5'd0; d1 = 8'h55;
    cycle();
    req1 = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    cycle();
    chk("err_clear", 32'(err), 32'd0);
    read_expect("rd_0_1", 0, 1, 8'h20);
    read_expect("rd_70_0", 70, 0, 8'h20);

    // Tie for 4 cycles alternates grants
    ack_log.delete();
    req0 = 1'b1; x0 = 7'd0; y0 = 5'd0; d0 = 8'h41;
    req1 = 1'b1; x1 = 7'd1; y1 = 5'd0; d1 = 8'h42;
    run(4);
    req0 = 1'b0; req1 = 1'b0;
    cycle();
    exp_log = '{0, 1, 0, 1};
    chk("rr_len", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("rr_order", 32'(ack_log[i]), 32'(exp_log[i]));
    read_expect("rd_rr_0_0", 0, 0, 8'h41);
    read_expect("rd_rr_1_0", 1, 0, 8'h42);

    // Clear command beats a simultaneous request; request is served after the clear
    ack0_cnt = 0;
    req0 = 1'b1; x0 = 7'd10; y0 = 5'd10; d0 = 8'h77;
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    chk("clr_no_ack", 32'(ack0_cnt), 32'd0);
    chk("clr_busy", 32'(busy), 32'd1);
    dut_busy_cnt = 0;
    run(2100);
    chk("clr_held_ack", 32'(ack0_cnt), 32'd0);
    chk("busy_len_cmd", 32'(dut_busy_cnt), 32'd2100);
    cycle();
    req0 = 1'b0;
    chk("ack_after_clr", 32'(ack0_cnt), 32'd1);
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 70; x++) begin
        rd_x = 7'(x);
        rd_y = 5'(y);
        cycle();
      end
    cycle();

    // Reset in the middle of a clear restarts it from the beginning
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    run(1000);
    reset = 1'b1;
    #1;
    chk("midclr_busy", 32'(busy), 32'd1);
    chk("midclr_rd", 32'(rd_char), 32'h00);
    chk("midclr_addr", 32'(dut.clr_addr_q), 32'd0);
    @(posedge pclk); #1;
    reset = 1'b0;
    model_reset();
    dut_busy_cnt = 0;
    run(2110);
    chk("busy_len_rst", 32'(dut_busy_cnt), 32'd2100);

`ifdef VGA_TEXT_BLANK_WR_EN
    // Active display blocks writes
    ack0_cnt = 0;
    valid = 1'b1;
    req0 = 1'b1; x0 = 7'd2; y0 = 5'd2; d0 = 8'h66;
    run(5);
    chk("valid_no_ack", 32'(ack0_cnt), 32'd0);
    chk("valid_clr_addr", 32'(dut.clr_addr_q), 32'd0);
    valid = 1'b0;
    cycle();
    req0 = 1'b0;
    chk("blank_ack", 32'(ack0_cnt), 32'd1);
`endif

    // Random traffic with hold-until-ack requesters
    pend0 = 1'b0; pend1 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1'b1;
        x0 = 7'($urandom_range(0, 74));
        y0 = 5'($urandom_range(0, 31));
        d0 = 8'($urandom);
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1'b1;
        x1 = 7'($urandom_range(0, 74));
        y1 = 5'($urandom_range(0, 31));
        d1 = 8'($urandom);
      end
      req0  = pend0;
      req1  = pend1;
      rd_x  = 7'($urandom_range(0, 74));
      rd_y  = 5'($urandom_range(0, 31));
      valid = 1'($urandom_range(0, 1));
      cycle();
      if (m_g0) pend0 = 1'b0;
      if (m_g1) pend1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0; valid = 1'b0;
    run(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_text_arbiter.md
# vga_text_arbiter

Owns the 70×30 character buffer behind the VGA text display and schedules every access to it. The display pipeline reads one character cell per cycle from a dedicated read port using the character coordinates produced by the VGA timing generator. Two writers (input echo and calculator result) share the single write port under round-robin arbitration. A built-in clear engine fills the buffer with blanks after reset and on command.

## Interface
Parameters:
- COLS, 70, characters per row; x coordinates 0..COLS-1
- ROWS, 30, rows; y coordinates 0..ROWS-1
- BLANK_CHAR, 8'h20, code written by the clear engine and returned for out-of-range reads

Ports:
- pclk  in  1  pixel clock (25 MHz)
- reset  in  1  asynchronous, active-high
- valid  in  1  display-active flag from VGA timing; used only under the macro below
- rd_x  in  7  display read column
- rd_y  in  5  display read row
- rd_char  out  8  character at (rd_x, rd_y), registered
- req0 / req1  in  1  write request, requester 0 / 1
- x0, x1  in  7  write column
- y0, y1  in  5  write row
- d0, d1  in  8  write data
- ack0 / ack1  out  1  write accepted this cycle (combinational)
- clr_start  in  1  start full-buffer clear
- busy  out  1  clear engine running
- err  out  1  one-cycle pulse: out-of-range write was dropped

## Operation
- Storage: COLS*ROWS × 8-bit array. addr = y*COLS + x, 12 bits, range 0..2099. The multiply is built from shifts and adds (y*70 = (y<<6) + (y<<2) + (y<<1)).
- States: CLEAR and RUN.
- Async reset: state=CLEAR, clr_addr=0, last=1 (requester 0 wins the first tie), rd_char=8'h00, err=0, busy=1. Array contents are not reset directly; the clear engine overwrites them.
- CLEAR:
  - Each write-enabled cycle writes BLANK_CHAR to clr_addr, then increments clr_addr.
  - After addr 2099 is written: clr_addr=0, go to RUN.
  - clr_start is ignored. All acks are 0.
  - busy = (state==CLEAR).
- RUN:
  - If clr_start=1: go to CLEAR with clr_addr=0. No write and no ack that cycle, because clr_start beats the requests.
  - Otherwise, exactly one request: grant it.
  - Both requests: grant the requester that is not `last`. `last` updates to the granted index on every grant.
  - Granted requester sees ackN=1 in the same cycle. The write commits at the next rising edge.
  - Requesters hold req, x, y and d stable until ack. Deassert req the cycle after ack, or keep it high to issue a new back-to-back write.
- Out-of-range write (x≥COLS or y≥ROWS):
  - Granted and acked normally.
  - Array is unchanged.
  - err=1 on the following cycle.
- Read port: rd_char <= (rd_x<COLS && rd_y<ROWS) ? mem[addr] : BLANK_CHAR.
  - Same-address read and write in one cycle returns the old data (read-before-write).
  - Reads are never stalled, including during CLEAR.

## Timing
- Read latency: 1 cycle, every cycle.
- Write latency: ack cycle N, data visible on rd_char at cycle N+2 for a read issued at N+1.
- Throughput: one write per write-enabled cycle. A single requester holding req gets an ack every enabled cycle.
- Clear duration: 2100 write-enabled cycles. busy falls on the cycle after the last blank write.
- reset asserted mid-clear or mid-write: immediate return to the reset values above. The clear restarts from addr 0 after release. A write pending at the reset edge is not performed.

## Configuration
- VGA_TEXT_BLANK_WR_EN defined:
  - Writes happen only in cycles with valid=0; this applies to clear-engine writes and requester grants.
  - In cycles with valid=1, acks are 0 and clr_addr holds.
  - Clear therefore spans several frames.
- VGA_TEXT_BLANK_WR_EN undefined: valid is ignored and writes happen in any cycle.

## Test plan
- Reset, then idle:
  - busy=1 for exactly 2100 cycles, then 0.
  - Reading (0,0), (69,29) and (35,12) returns 8'h20.
  - rd_char=8'h00 during reset.
- req0 with x0=5, y0=3, d0=8'h31:
  - ack0 pulses once.
  - Read of (5,3) returns 8'h31; addr 215 is written.
  - Neighbours (4,3) and (6,3) remain 8'h20.
- req0 and req1 held together for 4 cycles, d0=8'h41 at (0,0), d1=8'h42 at (1,0):
  - Grant order is 0,1,0,1.
  - Final reads: (0,0)=8'h41, (1,0)=8'h42.
- req1 with x1=70, y1=0:
  - ack1=1, err=1 one cycle later.
  - (0,1) is unchanged.
  - Read of (70,0) returns 8'h20.
- In RUN, clr_start and req0 asserted in the same cycle:
  - ack0=0, busy=1 next cycle.
  - After 2100 cycles all cells are 8'h20. The request is then acked.
  - Assert reset at cycle 1000 of a clear: busy stays 1 and the clear restarts from 0.
- With VGA_TEXT_BLANK_WR_EN defined and valid=1 held:
  - req0 gets no ack and clr_addr does not advance.
  - Drop valid to 0: ack0 on the first valid=0 cycle.
